perceptron_trainer: RTL and testbench
=====================================

// Module: perceptron_trainer
//
// PURPOSE
//   Online trainer that writes the weights the perceptron classifier reads.
//   Accepts labelled binary samples over a valid/ready handshake.
//   Computes the current prediction serially and applies the perceptron learning rule on a mismatch.
//   Exposes the weights through a read port that feeds the classifier, and counts misclassifications.
//
// PARAMETERS
//   N_IN   8   number of binary input features
//   W_W    8   weight/bias width, two's complement
//   LR     1   learning-rate magnitude added/subtracted per update (1..2^(W_W-1)-1)
//   CNT_W  16  error counter width
//
// PORTS
//   clk           in   1          clock, all logic on rising edge
//   rst           in   1          synchronous reset, active-high
//   sample_valid  in   1          sample offered
//   sample_ready  out  1          trainer can accept a sample (high only in IDLE)
//   sample_x      in   N_IN       feature vector, bit i = feature i
//   sample_label  in   1          target class
//   train_en      in   1          sampled at accept; 1 = update on mismatch, 0 = inference only
//   result_valid  out  1          one-cycle pulse, pred/mismatch valid
//   pred          out  1          prediction of the last accepted sample
//   mismatch      out  1          pred != label of the last accepted sample
//   err_count     out  CNT_W      total mismatches since reset, saturating
//   w_rd_idx      in   clog2(N_IN+1)  weight index: 0 = bias, i = weight of feature i-1
//   w_rd_data     out  W_W        combinational read of the selected weight; out-of-range idx -> 0
//
// BEHAVIOUR
//   - Reset
//     - state=IDLE; all weights and bias 0; err_count=0.
//     - pred=0, mismatch=0, result_valid=0; sample_ready=1 in the first cycle after reset.
//     - Reset wins over every other event, in any state.
//   - Accept
//     - Transfer occurs on a clock edge with sample_valid && sample_ready.
//     - x, label and train_en are latched at that edge; inputs are ignored while busy.
//   - FSM: IDLE -> ACC -> DECIDE -> (UPDATE ->) IDLE
//     - ACC: N_IN+1 cycles. Cycle k=0 adds the bias; cycle k>0 adds w[k] if x[k-1]=1.
//     - Accumulator width W_W+clog2(N_IN+2), signed, no overflow possible.
//     - DECIDE: one cycle.
//       - pred = (sum >= 0); mismatch = (pred != label).
//       - result_valid=1 this cycle only.
//       - err_count += mismatch, holds at all-ones.
//       - Next state is UPDATE if train_en && mismatch, else IDLE.
//     - UPDATE: N_IN+1 cycles, index k as in ACC. Bias always updated; w[k] only if x[k-1]=1.
//       - label=1: add LR.
//       - label=0: subtract LR.
//       - Result saturates to [-2^(W_W-1), 2^(W_W-1)-1].
//   - Latency (accept at edge T)
//     - result_valid high in cycle T+N_IN+2.
//     - sample_ready high again at T+N_IN+3 without update, T+2*N_IN+4 with update.
//   - w_rd_data
//     - Reflects committed weights, one entry per UPDATE cycle.
//     - During UPDATE a read may show a mix of old and new weights; consumers sample only while sample_ready=1.
//   - pred/mismatch hold their value until the next DECIDE.
//
// TESTING (N_IN=8, W_W=8, LR=1 unless stated)
//   1. Reset -> all 9 weights read 0, err_count=0, sample_ready=1, result_valid=0.
//   2. x=8'h01, label=1, train_en=1 at T
//      -> sum=0, pred=1, mismatch=0, result_valid at T+10, ready at T+11, weights unchanged.
//   3. x=8'h03, label=0 after reset
//      -> pred=1, mismatch=1, err_count=1.
//      -> bias=-1, w[1]=w[2]=-1, others 0; ready at T+20.
//   4. LR=100 instance, three samples:
//      - x=01/label=0 -> bias=-100, w1=-100.
//      - x=02/label=1 -> bias=0, w2=100.
//      - x=03/label=0 -> bias=-100, w1 saturates to -128, w2=0.
//   5. train_en=0, x=8'h03, label=0
//      -> pred=1, mismatch=1, err_count=1, weights stay 0, ready at T+11.
//   6. rst asserted mid-UPDATE; sample_valid toggled while busy
//      -> weights 0, ready next cycle, busy-time offers never accepted.

Source files
------------

// File: rtl/perceptron_trainer.sv
// Online perceptron trainer: serial dot product over binary features and a
// saturating learning-rule update, with a combinational weight read port.
module perceptron_trainer #(
  parameter int N_IN  = 8,
  parameter int W_W   = 8,
  parameter int LR    = 1,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic [N_IN-1:0]              sample_x,
  input  logic                         sample_label,
  input  logic                         train_en,
  output logic                         result_valid,
  output logic                         pred,
  output logic                         mismatch,
  output logic [CNT_W-1:0]             err_count,
  input  logic [$clog2(N_IN+1)-1:0]    w_rd_idx,
  output logic [W_W-1:0]               w_rd_data
);

  localparam int IDX_W = $clog2(N_IN + 1);
  localparam int ACC_W = W_W + $clog2(N_IN + 2);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_IN);
  localparam logic signed [W_W-1:0] W_MAX   = {1'b0, {(W_W-1){1'b1}}};
  localparam logic signed [W_W-1:0] W_MIN   = {1'b1, {(W_W-1){1'b0}}};
  localparam logic [W_W:0]          LR_EXT  = (W_W+1)'(LR);

  typedef enum logic [1:0] {IDLE, ACC, DECIDE, UPDATE} state_t;

  state_t                  state, next_state;
  logic [IDX_W-1:0]        k;
  logic                    last_k;
  logic [N_IN:0]           x_ext;     // bit k holds feature k-1; bit 0 is the bias slot
  logic                    label_q;
  logic                    train_q;
  logic signed [W_W-1:0]   w [0:N_IN];
  logic signed [ACC_W-1:0] acc, acc_next;
  logic [W_W:0]            upd_wide;
  logic signed [W_W-1:0]   upd_sat;

  assign last_k       = (k == LAST_IDX);
  assign sample_ready = (state == IDLE);
  assign result_valid = (state == DECIDE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (sample_valid) next_state = ACC;
      ACC:     if (last_k)       next_state = DECIDE;
      DECIDE:  next_state = (train_q && mismatch) ? UPDATE : IDLE;
      UPDATE:  if (last_k)       next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    acc_next = acc;
    if (k == '0)      acc_next = ACC_W'(w[0]);
    else if (x_ext[k]) acc_next = acc + ACC_W'(w[k]);
  end

  // One extra bit catches overflow of the +/-LR step before clamping.
  always_comb begin
    upd_wide = label_q ? ({w[k][W_W-1], w[k]} + LR_EXT)
                       : ({w[k][W_W-1], w[k]} - LR_EXT);
    upd_sat  = upd_wide[W_W-1:0];
    if (upd_wide[W_W] != upd_wide[W_W-1]) upd_sat = upd_wide[W_W] ? W_MIN : W_MAX;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the weight array is a register file that must read zero after reset, so it is cleared here.
      for (int i = 0; i <= N_IN; i++) w[i] <= '0;
      acc       <= '0;
      k         <= '0;
      x_ext     <= '0;
      label_q   <= 1'b0;
      train_q   <= 1'b0;
      pred      <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      k <= ((state == ACC || state == UPDATE) && !last_k) ? k + 1'b1 : '0;
      unique case (state)
        IDLE: begin
          if (sample_valid) begin
            x_ext   <= {sample_x, 1'b0};
            label_q <= sample_label;
            train_q <= train_en;
          end
        end
        ACC: begin
          acc <= acc_next;
          if (last_k) begin
            pred     <= !acc_next[ACC_W-1];
            mismatch <= (!acc_next[ACC_W-1]) != label_q;
          end
        end
        DECIDE: begin
          if (mismatch && err_count != '1) err_count <= err_count + 1'b1;
        end
        UPDATE: begin
          if (k == '0 || x_ext[k]) w[k] <= upd_sat;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_rd_idx <= LAST_IDX) w_rd_data = w[w_rd_idx];
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: an LR=1 instance and an LR=100
// instance, checked against hand-computed results and cycle latencies.
module tb_perceptron_trainer;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_a, valid_b;
  logic [7:0]        x;
  logic              label, train;
  logic [3:0]        idx;
  logic              ready_a, ready_b, rv_a, rv_b, pred_a, pred_b, mis_a, mis_b;
  logic [15:0]       err_a, err_b;
  logic signed [7:0] wd_a, wd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perceptron_trainer #(.N_IN(8), .W_W(8), .LR(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .sample_valid(valid_a), .sample_ready(ready_a),
    .sample_x(x), .sample_label(label), .train_en(train),
    .result_valid(rv_a), .pred(pred_a), .mismatch(mis_a), .err_count(err_a),
    .w_rd_idx(idx), .w_rd_data(wd_a)
  );

  perceptron_trainer #(.N_IN(8), .W_W(8), .LR(100), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .sample_valid(valid_b), .sample_ready(ready_b),
    .sample_x(x), .sample_label(label), .train_en(train),
    .result_valid(rv_b), .pred(pred_b), .mismatch(mis_b), .err_count(err_b),
    .w_rd_idx(idx), .w_rd_data(wd_b)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_w(input bit sel, input int i, input int e);
    @(negedge clk);
    idx = 4'(i);
    #1;
    check($sformatf("%s.w[%0d]", sel ? "b" : "a", i), sel ? wd_b : wd_a, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offers one sample, then watches cycles T+1.. for the result pulse and ready.
  // With toggle set, junk offers are made while the trainer is busy.
  task automatic send(input bit sel, input logic [7:0] sx, input bit lbl, input bit tr,
                      input bit toggle, output int rv_cyc, output int rdy_cyc,
                      output bit p, output bit m);
    int pulses = 0;
    rv_cyc = 0; rdy_cyc = 0; p = 1'b0; m = 1'b0;
    @(negedge clk);
    check("ready_before_offer", sel ? ready_b : ready_a, 1);
    x = sx; label = lbl; train = tr;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0; valid_b = 1'b0;
    for (int j = 1; j <= 60 && rdy_cyc == 0; j++) begin
      @(negedge clk);
      if (sel ? rv_b : rv_a) begin
        pulses++;
        if (rv_cyc == 0) begin
          rv_cyc = j;
          p = sel ? pred_b : pred_a;
          m = sel ? mis_b : mis_a;
        end
      end
      if (sel ? ready_b : ready_a) rdy_cyc = j;
      if (toggle && j <= 8) begin
        x = 8'hFF; label = ~lbl; train = 1'b1;
        if (sel) valid_b = j[0]; else valid_a = j[0];
      end else begin
        valid_a = 1'b0; valid_b = 1'b0;
      end
    end
    check("result_pulses", pulses, 1);
  endtask

  int rvc, rdc;
  bit p, m;

  initial begin
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; x = '0; label = 1'b0; train = 1'b0; idx = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready", ready_a, 1);
    check("rst_rv", rv_a, 0);
    check("rst_err", err_a, 0);
    check("rst_pred", pred_a, 0);
    check("rst_mismatch", mis_a, 0);
    for (int i = 0; i <= 8; i++) check_w(0, i, 0);

    // Correct prediction, no update
    send(0, 8'h01, 1'b1, 1'b1, 1'b0, rvc, rdc, p, m);
    check("t2_rv_cycle", rvc, 10);
    check("t2_ready_cycle", rdc, 11);
    check("t2_pred", p, 1);
    check("t2_mismatch", m, 0);
    check("t2_err", err_a, 0);
    check_w(0, 0, 0);
    check_w(0, 1, 0);

    // Mismatch with update; junk offers while busy must be ignored
    do_reset();
    send(0, 8'h03, 1'b0, 1'b1, 1'b1, rvc, rdc, p, m);
    check("t3_rv_cycle", rvc, 10);
    check("t3_ready_cycle", rdc, 20);
    check("t3_pred", p, 1);
    check("t3_mismatch", m, 1);
    check("t3_err", err_a, 1);
    check_w(0, 0, -1);
    check_w(0, 1, -1);
    check_w(0, 2, -1);
    for (int i = 3; i <= 8; i++) check_w(0, i, 0);
    check_w(0, 9, 0);
    check_w(0, 15, 0);
    check("t3_pred_hold", pred_a, 1);

    // Inference only
    do_reset();
    send(0, 8'h03, 1'b0, 1'b0, 1'b0, rvc, rdc, p, m);
    check("t5_rv_cycle", rvc, 10);
    check("t5_ready_cycle", rdc, 11);
    check("t5_pred", p, 1);
    check("t5_mismatch", m, 1);
    check("t5_err", err_a, 1);
    for (int i = 0; i <= 2; i++) check_w(0, i, 0);

    // LR=100 instance, saturation on the third sample
    do_reset();
    send(1, 8'h01, 1'b0, 1'b1, 1'b0, rvc, rdc, p, m);
    check("t4a_ready_cycle", rdc, 20);
    check("t4a_pred", p, 1);
    check_w(1, 0, -100);
    check_w(1, 1, -100);
    check_w(1, 2, 0);
    send(1, 8'h02, 1'b1, 1'b1, 1'b0, rvc, rdc, p, m);
    check("t4b_pred", p, 0);
    check("t4b_mismatch", m, 1);
    check_w(1, 0, 0);
    check_w(1, 1, -100);
    check_w(1, 2, 100);
    send(1, 8'h03, 1'b0, 1'b1, 1'b0, rvc, rdc, p, m);
    check("t4c_pred", p, 1);
    check("t4c_mismatch", m, 1);
    check_w(1, 0, -100);
    check_w(1, 1, -128);
    check_w(1, 2, 0);
    check("t4_err", err_b, 3);

    // Reset in the middle of UPDATE, with an offer present at the reset edge
    @(negedge clk);
    x = 8'h03; label = 1'b0; train = 1'b1; valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    repeat (13) @(negedge clk);
    check("t6_busy", ready_a, 0);
    rst = 1'b1; valid_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid_a = 1'b0;
    check("t6_ready", ready_a, 1);
    check("t6_rv", rv_a, 0);
    check("t6_err", err_a, 0);
    check("t6_pred", pred_a, 0);
    for (int i = 0; i <= 8; i++) check_w(0, i, 0);
    send(0, 8'h01, 1'b1, 1'b1, 1'b0, rvc, rdc, p, m);
    check("t6_post_rv_cycle", rvc, 10);
    check("t6_post_ready_cycle", rdc, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
